// File: rtl/dag_pkg.sv
// ---------------------------------------------------------------------------
// dag_pkg
//   Shared definitions for the DAG post-modify address sequencer: the default
//   index width and the one-pass-per-state FSM encoding.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dag_pkg;

  // Index/address width; the shared adder is one bit wider (CLA15_0).
  localparam int DAG_ADDR_W = 14;

  // One adder pass per non-IDLE state.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LIN  = 3'd1,
    ST_SUBB = 3'd2,
    ST_ADDM = 3'd3,
    ST_WRAP = 3'd4,
    ST_ADDB = 3'd5
  } dag_state_t;

endpackage

`default_nettype wire

// File: rtl/dag_rr_arb.sv
// ---------------------------------------------------------------------------
// dag_rr_arb
//   Round-robin arbiter. The search starts at the pointer and skips masked
//   requesters. Outputs a one-hot grant, its index and a valid flag.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dag_rr_arb #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             valid
);

  logic [N_REQ-1:0]   eligible;
  logic [2*N_REQ-1:0] rotated;
  logic [IDX_W:0]     cand;

  // Rotate eligible requests so that bit 0 is the pointer slot, then take the first set bit.
  always_comb begin
    eligible  = req & ~mask;
    rotated   = {eligible, eligible} >> ptr;
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!valid && rotated[k]) begin
        valid = 1'b1;
        cand  = {1'b0, ptr} + (IDX_W+1)'(k);
        if (cand >= (IDX_W+1)'(N_REQ)) begin
          cand = cand - (IDX_W+1)'(N_REQ);
        end
        grant_idx = cand[IDX_W-1:0];
      end
    end
    if (valid) begin
      grant = N_REQ'(1) << grant_idx;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dag_circ_seq.sv
// ---------------------------------------------------------------------------
// dag_circ_seq
//   Post-modify address sequencer. N_REQ index-register ports share one
//   external ADDR_W+1 bit adder. Linear updates take one adder pass. Circular
//   updates take four: offset = I-B, offset+M, a single wrap correction by L,
//   then +B. The updated index is returned with a one-cycle ACK pulse.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dag_circ_seq
  import dag_pkg::*;
#(
  parameter int ADDR_W = DAG_ADDR_W,
  parameter int N_REQ  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] i_in,
  input  logic [N_REQ*ADDR_W-1:0] m_in,
  input  logic [N_REQ*ADDR_W-1:0] l_in,
  input  logic [N_REQ*ADDR_W-1:0] b_in,
  output logic [ADDR_W:0]         add_a,
  output logic [ADDR_W:0]         add_b,
  output logic                    add_cin,
  input  logic [ADDR_W:0]         add_sum,
  output logic [N_REQ-1:0]        ack,
  output logic [ADDR_W-1:0]       res,
  output logic                    busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  dag_state_t        state;
  dag_state_t        state_nxt;
  logic [IDX_W-1:0]  rr_ptr;
  logic [N_REQ-1:0]  owner;

  // Latched operands, sign-extended to the adder width.
  logic [ADDR_W:0]   op_i;
  logic [ADDR_W:0]   op_m;
  logic [ADDR_W:0]   op_l;
  logic [ADDR_W:0]   op_b;
  logic [ADDR_W:0]   t_reg;

  logic [N_REQ-1:0]  grant;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_valid;
  logic              arb_valid;

  logic [ADDR_W-1:0] sel_i;
  logic [ADDR_W-1:0] sel_m;
  logic [ADDR_W-1:0] sel_l;
  logic [ADDR_W-1:0] sel_b;

  // The requester acked this cycle is masked, so its stale REQ is not regranted.
  dag_rr_arb #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req       (req),
    .mask      (ack),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .valid     (arb_valid)
  );

  assign grant_valid = arb_valid && (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);

  // Select the granted requester's operand slots.
  always_comb begin
    sel_i = '0;
    sel_m = '0;
    sel_l = '0;
    sel_b = '0;
    for (int n = 0; n < N_REQ; n++) begin
      if (grant[n]) begin
        sel_i = i_in[n*ADDR_W +: ADDR_W];
        sel_m = m_in[n*ADDR_W +: ADDR_W];
        sel_l = l_in[n*ADDR_W +: ADDR_W];
        sel_b = b_in[n*ADDR_W +: ADDR_W];
      end
    end
  end

  // Next state and adder operands. Operands are zero in IDLE so the shared adder stays quiet.
  always_comb begin
    state_nxt = state;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_valid) begin
          state_nxt = (sel_l == '0) ? ST_LIN : ST_SUBB;
        end
      end
      ST_LIN: begin
        add_a     = op_i;
        add_b     = op_m;
        state_nxt = ST_IDLE;
      end
      ST_SUBB: begin
        add_a     = op_i;
        add_b     = ~op_b;
        add_cin   = 1'b1;
        state_nxt = ST_ADDM;
      end
      ST_ADDM: begin
        add_a     = t_reg;
        add_b     = op_m;
        state_nxt = ST_WRAP;
      end
      ST_WRAP: begin
        add_a = t_reg;
        if (!op_m[ADDR_W]) begin
          add_b   = ~op_l;
          add_cin = 1'b1;
        end else begin
          add_b   = op_l;
        end
        state_nxt = ST_ADDB;
      end
      ST_ADDB: begin
        add_a     = t_reg;
        add_b     = op_b;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant handling: latch operands, record owner and advance the round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      owner  <= '0;
      op_i   <= '0;
      op_m   <= '0;
      op_l   <= '0;
      op_b   <= '0;
    end else if (grant_valid) begin
      rr_ptr <= (grant_idx == IDX_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
      owner  <= grant;
      op_i   <= {sel_i[ADDR_W-1], sel_i};
      op_m   <= {sel_m[ADDR_W-1], sel_m};
      op_l   <= {sel_l[ADDR_W-1], sel_l};
      op_b   <= {sel_b[ADDR_W-1], sel_b};
    end
  end

  // Capture each pass result. The wrap pass keeps the corrected sum only when a wrap occurred.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_reg <= '0;
    end else begin
      case (state)
        ST_SUBB, ST_ADDM: t_reg <= add_sum;
        ST_WRAP: begin
          if (!op_m[ADDR_W]) begin
            if (!add_sum[ADDR_W]) t_reg <= add_sum;
          end else begin
            if (t_reg[ADDR_W]) t_reg <= add_sum;
          end
        end
        default: t_reg <= t_reg;
      endcase
    end
  end

  // Result and one-cycle ACK on the final pass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res <= '0;
      ack <= '0;
    end else begin
      ack <= '0;
      if (state == ST_LIN || state == ST_ADDB) begin
        res <= add_sum[ADDR_W-1:0];
        ack <= owner;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dag_circ_seq.sv
// ---------------------------------------------------------------------------
// tb_dag_circ_seq
//   Directed bench for dag_circ_seq. It models the external adder and checks
//   latency, result and arbitration against hand-computed values.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dag_circ_seq;

  localparam int AW = 14;
  localparam int NR = 2;

  logic             clk;
  logic             rst;
  logic [NR-1:0]    req;
  logic [NR*AW-1:0] i_in;
  logic [NR*AW-1:0] m_in;
  logic [NR*AW-1:0] l_in;
  logic [NR*AW-1:0] b_in;
  logic [AW:0]      add_a;
  logic [AW:0]      add_b;
  logic             add_cin;
  logic [AW:0]      add_sum;
  logic [NR-1:0]    ack;
  logic [AW-1:0]    res;
  logic             busy;

  int checks;
  int failures;

  dag_circ_seq #(.ADDR_W(AW), .N_REQ(NR)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .i_in    (i_in),
    .m_in    (m_in),
    .l_in    (l_in),
    .b_in    (b_in),
    .add_a   (add_a),
    .add_b   (add_b),
    .add_cin (add_cin),
    .add_sum (add_sum),
    .ack     (ack),
    .res     (res),
    .busy    (busy)
  );

  // External CLA15_0 stand-in.
  assign add_sum = add_a + add_b + {{AW{1'b0}}, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Load a slot, raise its REQ at cycle 0, then wait for ACK. Returns at #1 after the edge following ACK.
  task automatic run_req(input int n, input logic [AW-1:0] iv, input logic [AW-1:0] mv,
                         input logic [AW-1:0] lv, input logic [AW-1:0] bv,
                         output int lat, output logic [NR-1:0] ackv, output logic [AW-1:0] resv);
    i_in[n*AW +: AW] = iv;
    m_in[n*AW +: AW] = mv;
    l_in[n*AW +: AW] = lv;
    b_in[n*AW +: AW] = bv;
    req[n] = 1'b1;
    lat  = -1;
    ackv = '0;
    resv = '0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (ack !== '0) begin
        lat  = c;
        ackv = ack;
        resv = res;
        break;
      end
    end
    req[n] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    i_in = '0; m_in = '0; l_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || ack !== '0 || res !== '0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%b ack=%b res=%h, required 0/00/0000", busy, ack, res);
    end
    checks++;
    if (add_a !== '0 || add_b !== '0 || add_cin !== 1'b0) begin
      failures++;
      $display("FAIL reset_adder: a=%h b=%h cin=%b, required zeros", add_a, add_b, add_cin);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_linear();
    int lat; logic [NR-1:0] a; logic [AW-1:0] r;
    run_req(0, 14'h0100, 14'h0004, 14'h0000, 14'h0000, lat, a, r);
    checks++;
    if (lat !== 2 || a !== 2'b01 || r !== 14'h0104) begin
      failures++;
      $display("FAIL linear_basic: lat=%0d ack=%b res=%h, required 2/01/0104", lat, a, r);
    end
    run_req(1, 14'h3FFF, 14'h0002, 14'h0000, 14'h0000, lat, a, r);
    checks++;
    if (lat !== 2 || a !== 2'b10 || r !== 14'h0001) begin
      failures++;
      $display("FAIL linear_overflow: lat=%0d ack=%b res=%h, required 2/10/0001", lat, a, r);
    end
    checks++;
    if (busy !== 1'b0 || add_a !== '0 || add_b !== '0 || add_cin !== 1'b0) begin
      failures++;
      $display("FAIL idle_quiet: busy=%b a=%h b=%h cin=%b, required 0 and zeros", busy, add_a, add_b, add_cin);
    end
  endtask

  task automatic test_circular();
    logic [AW-1:0] vi [6] = '{14'h0206, 14'h0207, 14'h0201, 14'h0200, 14'h0202, 14'h0202};
    logic [AW-1:0] vm [6] = '{14'h0003, 14'h0001, 14'h3FFD, 14'h3FFF, 14'h0002, 14'h0000};
    logic [AW-1:0] ve [6] = '{14'h0201, 14'h0200, 14'h0206, 14'h0207, 14'h0204, 14'h0202};
    int lat; logic [NR-1:0] a; logic [AW-1:0] r;
    for (int k = 0; k < 6; k++) begin
      run_req(k % 2, vi[k], vm[k], 14'h0008, 14'h0200, lat, a, r);
      checks++;
      if (lat !== 5 || r !== ve[k] || a !== (2'b01 << (k % 2))) begin
        failures++;
        $display("FAIL circular_%0d: lat=%0d ack=%b res=%h, required 5/%b/%h",
                 k, lat, a, r, 2'b01 << (k % 2), ve[k]);
      end
    end
  endtask

  task automatic test_arbitration();
    logic [NR-1:0] exp_ack [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [AW-1:0] exp_res [4] = '{14'h0011, 14'h0022, 14'h0011, 14'h0022};
    int got;
    // Restart from a known pointer.
    rst = 1'b1; #2; rst = 1'b0;
    @(posedge clk); #1;
    i_in = {14'h0020, 14'h0010};
    m_in = {14'h0002, 14'h0001};
    l_in = '0;
    b_in = '0;
    req  = 2'b11;
    for (int g = 0; g < 4; g++) begin
      got = 0;
      for (int c = 1; c <= 10; c++) begin
        @(posedge clk); #1;
        if (ack !== '0) begin got = c; break; end
      end
      checks++;
      if (got !== 2 || ack !== exp_ack[g] || res !== exp_res[g]) begin
        failures++;
        $display("FAIL rr_grant_%0d: lat=%0d ack=%b res=%h, required 2/%b/%h",
                 g, got, ack, res, exp_ack[g], exp_res[g]);
      end
    end
    req = 2'b00;
    @(posedge clk); #1;
    // Pointer now at 0: only REQ[0], then hold it one cycle past ACK while REQ[1] arrives.
    req = 2'b01;
    got = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (ack !== '0) begin got = c; break; end
    end
    checks++;
    if (got !== 2 || ack !== 2'b01) begin
      failures++;
      $display("FAIL stale_first_ack: lat=%0d ack=%b, required 2/01", got, ack);
    end
    req = 2'b11;
    @(posedge clk); #1;
    req = 2'b10;
    got = 0;
    for (int c = 1; c <= 10; c++) begin
      if (ack !== '0) begin got = c; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (got !== 2 || ack !== 2'b10 || res !== 14'h0022) begin
      failures++;
      $display("FAIL stale_next_grant: lat=%0d ack=%b res=%h, required 2/10/0022", got, ack, res);
    end
    req = 2'b00;
    @(posedge clk); #1;
    // Stale REQ alone must not restart the sequencer.
    req = 2'b01;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (ack !== '0) break;
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL stale_no_regrant: busy=%b, required 0", busy);
    end
    req = 2'b00;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    int lat; logic [NR-1:0] a; logic [AW-1:0] r;
    int seen;
    i_in[0 +: AW] = 14'h0206;
    m_in[0 +: AW] = 14'h0003;
    l_in[0 +: AW] = 14'h0008;
    b_in[0 +: AW] = 14'h0200;
    req[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || add_cin !== 1'b1 || add_b !== ~{1'b0, 14'h0008}) begin
      failures++;
      $display("FAIL abort_in_wrap: busy=%b b=%h cin=%b, required 1/%h/1", busy, add_b, add_cin, ~{1'b0, 14'h0008});
    end
    rst = 1'b1;
    req = '0;
    #1;
    checks++;
    if (busy !== 1'b0 || add_a !== '0 || add_b !== '0 || add_cin !== 1'b0 || ack !== '0) begin
      failures++;
      $display("FAIL abort_immediate: busy=%b a=%h b=%h cin=%b ack=%b, required all zero",
               busy, add_a, add_b, add_cin, ack);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack !== '0) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL abort_no_ack: ack_pulses=%0d, required 0", seen);
    end
    run_req(0, 14'h0100, 14'h0004, 14'h0000, 14'h0000, lat, a, r);
    checks++;
    if (lat !== 2 || a !== 2'b01 || r !== 14'h0104) begin
      failures++;
      $display("FAIL abort_recover: lat=%0d ack=%b res=%h, required 2/01/0104", lat, a, r);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    req      = '0;
    test_reset();
    test_linear();
    test_circular();
    test_arbitration();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
